// File: rtl/paint_shape_engine_pkg.sv
// Shared types for the paint shape engine: FSM state encoding and draw-mode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package paint_shape_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_P2 = 3'd1,
        ST_NORM   = 3'd2,
        ST_SCAN   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] MODE_NONE    = 2'b00;
    localparam logic [1:0] MODE_FREE    = 2'b01;
    localparam logic [1:0] MODE_FILL    = 2'b10;
    localparam logic [1:0] MODE_OUTLINE = 2'b11;

    // Both rectangle modes need a second corner; freeform does not.
    function automatic logic is_rect(input logic [1:0] m);
        return m[1];
    endfunction

endpackage

// File: rtl/paint_shape_engine_if.sv
// Pixel request stream from the shape engine to the VGA adapter write port.
// Latency: n/a (wiring only).
// Backpressure: the slave holds plot_ready low to stall; the master holds x/y/colour stable while plot is high.
// Ports: plot (valid), plot_ready (ready), x_out, y_out, colour_out.
interface paint_shape_engine_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
);
    logic           plot;
    logic           plot_ready;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [C_W-1:0] colour_out;

    modport master (output plot, x_out, y_out, colour_out, input plot_ready);
    modport slave  (input plot, x_out, y_out, colour_out, output plot_ready);
endinterface

// File: rtl/paint_shape_engine_rect_scanner.sv
// Raster walker over an inclusive rectangle, x fastest; flags border pixels and the final pixel.
// Latency: bounds and counters take effect the cycle after i_load; one pixel per i_step.
// Backpressure: holds position while i_step is low; never steps past the last pixel.
// Ports: Clock, reset_N, i_xmin/i_xmax/i_ymin/i_ymax, i_load, i_step -> o_cx, o_cy, o_on_border, o_last.
module rect_scanner #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           Clock,
    input  logic           reset_N,
    input  logic [X_W-1:0] i_xmin,
    input  logic [X_W-1:0] i_xmax,
    input  logic [Y_W-1:0] i_ymin,
    input  logic [Y_W-1:0] i_ymax,
    input  logic           i_load,
    input  logic           i_step,
    output logic [X_W-1:0] o_cx,
    output logic [Y_W-1:0] o_cy,
    output logic           o_on_border,
    output logic           o_last
);
    logic [X_W-1:0] r_xmin, r_xmax, r_cx;
    logic [Y_W-1:0] r_ymin, r_ymax, r_cy;

    always_ff @(posedge Clock or negedge reset_N) begin
        if (!reset_N) begin
            r_xmin <= '0;
            r_xmax <= '0;
            r_ymin <= '0;
            r_ymax <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
        end else if (i_load) begin
            r_xmin <= i_xmin;
            r_xmax <= i_xmax;
            r_ymin <= i_ymin;
            r_ymax <= i_ymax;
            r_cx   <= i_xmin;
            r_cy   <= i_ymin;
        end else if (i_step && !o_last) begin
            // Compare against the bound before incrementing so a bound at
            // the all-ones value never wraps the counter.
            if (r_cx == r_xmax) begin
                r_cx <= r_xmin;
                r_cy <= r_cy + Y_W'(1);
            end else begin
                r_cx <= r_cx + X_W'(1);
            end
        end
    end

    assign o_cx        = r_cx;
    assign o_cy        = r_cy;
    assign o_on_border = (r_cx == r_xmin) || (r_cx == r_xmax) ||
                         (r_cy == r_ymin) || (r_cy == r_ymax);
    assign o_last      = (r_cx == r_xmax) && (r_cy == r_ymax);
endmodule

// File: rtl/paint_shape_engine.sv
// Captures one or two clamped corners on start rising edges, then streams freeform/filled/outline pixels.
// Latency: first pixel two cycles after the final corner capture; one pixel per accepted handshake.
// Backpressure: plot stays high with stable x/y/colour until plot_ready; skipped outline pixels cost one cycle.
// Ports: Clock, reset_N, start, mode, coord_x, coord_y, colour_in, cancel, plot_if (master), busy, done.
module paint_shape_engine
    import paint_shape_engine_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic                        Clock,
    input  logic                        reset_N,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [X_W-1:0]              coord_x,
    input  logic [Y_W-1:0]              coord_y,
    input  logic [C_W-1:0]              colour_in,
    input  logic                        cancel,
    paint_shape_engine_if.master        plot_if,
    output logic                        busy,
    output logic                        done
);
    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    state_t         r_state, w_next;
    logic           r_start_q;
    logic [X_W-1:0] r_x1, r_x2;
    logic [Y_W-1:0] r_y1, r_y2;
    logic [C_W-1:0] r_colour;
    logic [1:0]     r_mode;

    logic           w_go, w_cap1, w_cap2, w_load, w_step, w_emit;
    logic [X_W-1:0] w_x_clamp, w_xmin, w_xmax, w_cx;
    logic [Y_W-1:0] w_y_clamp, w_ymin, w_ymax, w_cy;
    logic           w_on_border, w_last;

    assign w_go      = start && !r_start_q;
    assign w_x_clamp = (coord_x > X_LIM) ? X_LIM : coord_x;
    assign w_y_clamp = (coord_y > Y_LIM) ? Y_LIM : coord_y;
    assign w_xmin    = (r_x1 < r_x2) ? r_x1 : r_x2;
    assign w_xmax    = (r_x1 < r_x2) ? r_x2 : r_x1;
    assign w_ymin    = (r_y1 < r_y2) ? r_y1 : r_y2;
    assign w_ymax    = (r_y1 < r_y2) ? r_y2 : r_y1;
    assign w_emit    = (r_mode != MODE_OUTLINE) || w_on_border;

    always_ff @(posedge Clock or negedge reset_N) begin
        if (!reset_N) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_colour  <= '0;
            r_mode    <= MODE_NONE;
        end else begin
            r_state   <= w_next;
            r_start_q <= start;
            if (w_cap1) begin
                // Second corner defaults to the first so freeform is a 1x1 rectangle.
                r_x1     <= w_x_clamp;
                r_y1     <= w_y_clamp;
                r_x2     <= w_x_clamp;
                r_y2     <= w_y_clamp;
                r_colour <= colour_in;
                r_mode   <= mode;
            end
            if (w_cap2) begin
                r_x2 <= w_x_clamp;
                r_y2 <= w_y_clamp;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_cap1 = 1'b0;
        w_cap2 = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        if (cancel) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go && (mode != MODE_NONE)) begin
                        w_cap1 = 1'b1;
                        w_next = is_rect(mode) ? ST_GET_P2 : ST_NORM;
                    end
                end
                ST_GET_P2: begin
                    if (w_go) begin
                        w_cap2 = 1'b1;
                        w_next = ST_NORM;
                    end
                end
                ST_NORM: begin
                    w_load = 1'b1;
                    w_next = ST_SCAN;
                end
                ST_SCAN: begin
                    // Non-emitted outline pixels advance without a handshake.
                    w_step = !w_emit || plot_if.plot_ready;
                    if (w_step && w_last)
                        w_next = ST_FINISH;
                end
                ST_FINISH: w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    rect_scanner #(.X_W(X_W), .Y_W(Y_W)) u_scan (
        .Clock       (Clock),
        .reset_N     (reset_N),
        .i_xmin      (w_xmin),
        .i_xmax      (w_xmax),
        .i_ymin      (w_ymin),
        .i_ymax      (w_ymax),
        .i_load      (w_load),
        .i_step      (w_step),
        .o_cx        (w_cx),
        .o_cy        (w_cy),
        .o_on_border (w_on_border),
        .o_last      (w_last)
    );

    assign plot_if.plot       = (r_state == ST_SCAN) && w_emit;
    assign plot_if.x_out      = w_cx;
    assign plot_if.y_out      = w_cy;
    assign plot_if.colour_out = r_colour;
    assign busy               = (r_state != ST_IDLE);
    assign done               = (r_state == ST_FINISH);
endmodule

// File: tb/tb_paint_shape_engine.sv
module tb_paint_shape_engine;
    logic       Clock     = 1'b0;
    logic       reset_N   = 1'b0;
    logic       start     = 1'b0;
    logic       cancel    = 1'b0;
    logic [1:0] mode      = 2'b00;
    logic [7:0] coord_x   = '0;
    logic [6:0] coord_y   = '0;
    logic [2:0] colour_in = '0;
    logic       busy, done;

    paint_shape_engine_if ifc ();

    paint_shape_engine dut (
        .Clock     (Clock),
        .reset_N   (reset_N),
        .start     (start),
        .mode      (mode),
        .coord_x   (coord_x),
        .coord_y   (coord_y),
        .colour_in (colour_in),
        .cancel    (cancel),
        .plot_if   (ifc),
        .busy      (busy),
        .done      (done)
    );

    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_pass = 0;
    int qx[$], qy[$], qc[$];
    int ex[$], ey[$];
    int n_done, first_acc, last_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic press(input int x, input int y);
        @(posedge Clock); #1;
        coord_x = 8'(x);
        coord_y = 7'(y);
        start   = 1'b1;
        @(posedge Clock); #1;
        start   = 1'b0;
    endtask

    // Observe ncyc cycles at the falling edge, logging accepted pixels and done pulses.
    task automatic run(input int ncyc);
        qx.delete(); qy.delete(); qc.delete();
        n_done = 0; first_acc = -1; last_acc = -1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge Clock);
            if (ifc.plot && ifc.plot_ready) begin
                qx.push_back(int'(ifc.x_out));
                qy.push_back(int'(ifc.y_out));
                qc.push_back(int'(ifc.colour_out));
                if (first_acc < 0) first_acc = i;
                last_acc = i;
            end
            if (done) n_done++;
        end
    endtask

    task automatic check_list(input string t);
        chk({t, "_count"}, qx.size(), ex.size());
        for (int i = 0; i < ex.size(); i++) begin
            if (i < qx.size()) begin
                chk($sformatf("%s_x%0d", t, i), qx[i], ex[i]);
                chk($sformatf("%s_y%0d", t, i), qy[i], ey[i]);
            end
        end
    endtask

    initial begin
        int found, acc, dsum, psum;
        ifc.plot_ready = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_plot",   ifc.plot,       0);
        chk("rst_busy",   busy,           0);
        chk("rst_done",   done,           0);
        chk("rst_x",      ifc.x_out,      0);
        chk("rst_y",      ifc.y_out,      0);
        chk("rst_colour", ifc.colour_out, 0);
        reset_N = 1'b1;

        // 1: filled rectangle from (5,3)/(3,4)
        mode = 2'b10; colour_in = 3'd5;
        press(5, 3);
        press(3, 4);
        run(20);
        ex = '{3, 4, 5, 3, 4, 5};
        ey = '{3, 3, 3, 4, 4, 4};
        check_list("fill");
        chk("fill_colour", qc.size() > 0 ? qc[0] : -1, 5);
        chk("fill_done",   n_done, 1);
        chk("fill_idle",   busy,   0);

        // 2: outline (0,0)-(2,2), centre skipped but still costs a SCAN cycle
        mode = 2'b11;
        press(0, 0);
        press(2, 2);
        run(20);
        ex = '{0, 1, 2, 0, 2, 0, 1, 2};
        ey = '{0, 0, 0, 1, 1, 2, 2, 2};
        check_list("outl");
        chk("outl_span", last_acc - first_acc + 1, 9);
        chk("outl_done", n_done, 1);

        // 3: backpressure on the first pixel
        mode = 2'b10;
        @(posedge Clock); #1;
        ifc.plot_ready = 1'b0;
        press(10, 10);
        press(11, 10);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (ifc.plot) begin found = 1; break; end
        end
        chk("bp_seen", found, 1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge Clock); #1;
                if (k == 3) ifc.plot_ready = 1'b1;
                @(negedge Clock);
            end
            chk($sformatf("bp_hold_plot%0d", k), ifc.plot,  1);
            chk($sformatf("bp_hold_x%0d", k),    ifc.x_out, 10);
            chk($sformatf("bp_hold_y%0d", k),    ifc.y_out, 10);
        end
        run(10);
        ex = '{11};
        ey = '{10};
        check_list("bp");
        chk("bp_done", n_done, 1);

        // 4: freeform clamp at the far corner
        mode = 2'b01; colour_in = 3'd2;
        press(200, 127);
        run(10);
        ex = '{159};
        ey = '{119};
        check_list("clamp");
        chk("clamp_colour", qc.size() > 0 ? qc[0] : -1, 2);
        chk("clamp_done",   n_done, 1);
        chk("clamp_idle",   busy,   0);

        // 5: cancel after the fourth accepted pixel
        mode = 2'b10;
        press(0, 0);
        press(9, 9);
        acc = 0;
        for (int i = 0; i < 50 && acc < 4; i++) begin
            @(negedge Clock);
            if (ifc.plot && ifc.plot_ready) acc++;
        end
        chk("cancel_acc", acc, 4);
        @(posedge Clock); #1;
        cancel = 1'b1;
        @(negedge Clock);
        chk("cancel_done_a", done, 0);
        @(posedge Clock); #1;
        cancel = 1'b0;
        @(negedge Clock);
        chk("cancel_plot", ifc.plot, 0);
        chk("cancel_busy", busy,     0);
        chk("cancel_done", done,     0);
        run(20);
        chk("cancel_noplot", qx.size(), 0);
        chk("cancel_nodone", n_done,    0);

        // 6: start held high -> one capture only; mode change after capture ignored
        @(posedge Clock); #1;
        mode = 2'b10; coord_x = 8'd7; coord_y = 7'd8; start = 1'b1;
        @(posedge Clock); #1;
        coord_x = 8'd50; coord_y = 7'd50; mode = 2'b11;
        dsum = 0; psum = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge Clock);
            dsum += int'(done);
            psum += int'(ifc.plot);
        end
        chk("hold_busy",   busy, 1);
        chk("hold_nodone", dsum, 0);
        chk("hold_noplot", psum, 0);
        @(posedge Clock); #1;
        start = 1'b0;
        press(9, 10);
        run(25);
        ex = '{7, 8, 9, 7, 8, 9, 7, 8, 9};
        ey = '{8, 8, 8, 9, 9, 9, 10, 10, 10};
        check_list("hold");
        chk("hold_done", n_done, 1);

        // 7: reset in the middle of a scan
        mode = 2'b10;
        press(0, 0);
        press(9, 9);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (ifc.plot) begin found = 1; break; end
        end
        chk("rstmid_seen", found, 1);
        @(posedge Clock); #2;
        reset_N = 1'b0;
        #1;
        chk("rstmid_plot", ifc.plot,  0);
        chk("rstmid_busy", busy,      0);
        chk("rstmid_x",    ifc.x_out, 0);
        #3;
        reset_N = 1'b1;
        run(10);
        chk("rstmid_noplot", qx.size(), 0);
        chk("rstmid_nodone", n_done,    0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
